// File: rtl/sort_pkg.sv
// Shared state encoding and sizing helper for the sorter ingress path.
package sort_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RECV = 3'd1,
      DROP = 3'd2,
      WAIT = 3'd3,
      SEND = 3'd4
   } feeder_state_t;

   function automatic int max_len(input int awidth);
      return 2 ** awidth;
   endfunction

endpackage

// File: rtl/pkt_buf.sv
// Packet buffer: one write port, one registered read port, array never reset.
module pkt_buf
   import sort_pkg::*;
#(
   parameter int AWIDTH = 3,
   parameter int DWIDTH = 8
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [AWIDTH-1:0] waddr_i,
   input  logic [DWIDTH-1:0] wdata_i,
   input  logic              re_i,
   input  logic [AWIDTH-1:0] raddr_i,
   output logic [DWIDTH-1:0] rdata_o
);

   localparam int DEPTH = max_len(AWIDTH);

   logic [DWIDTH-1:0] r_mem [DEPTH];
   logic [DWIDTH-1:0] r_rdata;

   always_ff @(posedge clk_i) begin
      if (we_i) r_mem[waddr_i] <= wdata_i;
      if (re_i) r_rdata <= r_mem[raddr_i];
   end

   assign rdata_o = r_rdata;

endmodule

// File: rtl/sort_feeder.sv
// Collects one framed packet, validates its length, and replays it to the
// sorter back-to-back once the sorter reports not busy.
module sort_feeder
   import sort_pkg::*;
#(
   parameter int AWIDTH  = 3,
   parameter int DWIDTH  = 8,
   parameter int MIN_LEN = 2
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic [DWIDTH-1:0] data_i,
   input  logic              sop_i,
   input  logic              eop_i,
   input  logic              val_i,
   output logic              ready_o,
   input  logic              busy_i,
   output logic [DWIDTH-1:0] data_o,
   output logic              sop_o,
   output logic              eop_o,
   output logic              val_o,
   output logic              err_o
);

   localparam int              MAX_LEN = max_len(AWIDTH);
   localparam logic [AWIDTH:0] MAX_CNT = (AWIDTH+1)'(MAX_LEN);
   localparam logic [AWIDTH:0] MIN_CNT = (AWIDTH+1)'(MIN_LEN);
   localparam logic [AWIDTH:0] CNT_ONE = (AWIDTH+1)'(1);

   feeder_state_t     r_state, w_state_nxt;
   logic [AWIDTH:0]   r_wr_cnt, w_wr_cnt_nxt;
   logic [AWIDTH:0]   r_rd_ptr, w_rd_ptr_nxt;
   logic              w_accept, w_err;
   logic              w_we, w_re;
   logic [AWIDTH-1:0] w_waddr, w_raddr;
   logic [DWIDTH-1:0] w_rdata;
   logic              w_rd_vld, w_rd_sop, w_rd_eop;
   logic              r_rd_vld_p1, r_rd_sop_p1, r_rd_eop_p1;
   logic              r_ready, r_val, r_sop, r_eop, r_err;
   logic [DWIDTH-1:0] r_data;

   assign w_accept = val_i & r_ready;

   pkt_buf #(
      .AWIDTH (AWIDTH),
      .DWIDTH (DWIDTH)
   ) u_buf (
      .clk_i   (clk_i),
      .we_i    (w_we),
      .waddr_i (w_waddr),
      .wdata_i (data_i),
      .re_i    (w_re),
      .raddr_i (w_raddr),
      .rdata_o (w_rdata)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_wr_cnt_nxt = r_wr_cnt;
      w_rd_ptr_nxt = r_rd_ptr;
      w_err        = 1'b0;
      w_we         = 1'b0;
      w_waddr      = r_wr_cnt[AWIDTH-1:0];
      w_re         = 1'b0;
      w_raddr      = r_rd_ptr[AWIDTH-1:0];
      w_rd_vld     = 1'b0;
      w_rd_sop     = 1'b0;
      w_rd_eop     = 1'b0;
      case (r_state)
         IDLE, RECV, DROP: begin
            if (w_accept) begin
               // sop always restarts at addr 0, except sop+eop while dropping just ends the drop
               if (sop_i && !(r_state == DROP && eop_i)) begin
                  w_err        = (r_state == RECV);
                  w_we         = 1'b1;
                  w_waddr      = '0;
                  w_wr_cnt_nxt = CNT_ONE;
                  if (!eop_i) begin
                     w_state_nxt = RECV;
                  end else if (CNT_ONE < MIN_CNT) begin
                     w_err        = 1'b1;
                     w_wr_cnt_nxt = '0;
                     w_state_nxt  = IDLE;
                  end else begin
                     w_state_nxt = WAIT;
                  end
               end else if (r_state == IDLE) begin
                  w_err = 1'b1;
               end else if (r_state == DROP) begin
                  if (eop_i) w_state_nxt = IDLE;
               end else if (r_wr_cnt == MAX_CNT) begin
                  w_err        = 1'b1;
                  w_wr_cnt_nxt = '0;
                  w_state_nxt  = eop_i ? IDLE : DROP;
               end else begin
                  w_we         = 1'b1;
                  w_wr_cnt_nxt = r_wr_cnt + CNT_ONE;
                  if (eop_i) begin
                     if ((r_wr_cnt + CNT_ONE) < MIN_CNT) begin
                        w_err        = 1'b1;
                        w_wr_cnt_nxt = '0;
                        w_state_nxt  = IDLE;
                     end else begin
                        w_state_nxt = WAIT;
                     end
                  end
               end
            end
         end
         WAIT: begin
            if (!busy_i) begin
               w_state_nxt  = SEND;
               w_re         = 1'b1;
               w_raddr      = '0;
               w_rd_ptr_nxt = CNT_ONE;
               w_rd_vld     = 1'b1;
               w_rd_sop     = 1'b1;
               w_rd_eop     = (r_wr_cnt == CNT_ONE);
            end
         end
         SEND: begin
            if (r_eop) begin
               w_state_nxt  = IDLE;
               w_wr_cnt_nxt = '0;
            end else if (r_rd_ptr < r_wr_cnt) begin
               w_re         = 1'b1;
               w_rd_ptr_nxt = r_rd_ptr + CNT_ONE;
               w_rd_vld     = 1'b1;
               w_rd_eop     = (r_rd_ptr == (r_wr_cnt - CNT_ONE));
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge srst_i) begin
      if (srst_i) begin
         r_state     <= IDLE;
         r_wr_cnt    <= '0;
         r_rd_ptr    <= '0;
         r_rd_vld_p1 <= 1'b0;
         r_rd_sop_p1 <= 1'b0;
         r_rd_eop_p1 <= 1'b0;
         r_ready     <= 1'b1;
         r_val       <= 1'b0;
         r_sop       <= 1'b0;
         r_eop       <= 1'b0;
         r_err       <= 1'b0;
         r_data      <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_wr_cnt    <= w_wr_cnt_nxt;
         r_rd_ptr    <= w_rd_ptr_nxt;
         r_ready     <= (w_state_nxt != WAIT) && (w_state_nxt != SEND);
         r_err       <= w_err;
         // stage p1: framing travels alongside the buffer read
         r_rd_vld_p1 <= w_rd_vld;
         r_rd_sop_p1 <= w_rd_sop;
         r_rd_eop_p1 <= w_rd_eop;
         // stage p2: output registers
         r_val       <= r_rd_vld_p1;
         r_sop       <= r_rd_sop_p1;
         r_eop       <= r_rd_eop_p1;
         if (r_rd_vld_p1) r_data <= w_rdata;
      end
   end

   assign ready_o = r_ready;
   assign data_o  = r_data;
   assign sop_o   = r_sop;
   assign eop_o   = r_eop;
   assign val_o   = r_val;
   assign err_o   = r_err;

endmodule

// File: tb/tb_sort_feeder.sv
// Bench for sort_feeder: directed scenarios plus randomized framing against a
// queue-level packet model.
module tb_sort_feeder;

   localparam int MAX_LEN = 8;
   localparam int MIN_LEN = 2;

   logic       clk_i = 1'b0;
   logic       srst_i;
   logic [7:0] data_i;
   logic       sop_i, eop_i, val_i, busy_i;
   logic       ready_o, sop_o, eop_o, val_o, err_o;
   logic [7:0] data_o;
   logic       val1_i, busy1_i;
   logic       ready1_o, sop1_o, eop1_o, val1_o, err1_o;
   logic [7:0] data1_o;

   always #5 clk_i = ~clk_i;

   sort_feeder #(.AWIDTH(3), .DWIDTH(8), .MIN_LEN(MIN_LEN)) dut (
      .clk_i(clk_i), .srst_i(srst_i), .data_i(data_i), .sop_i(sop_i), .eop_i(eop_i),
      .val_i(val_i), .ready_o(ready_o), .busy_i(busy_i), .data_o(data_o),
      .sop_o(sop_o), .eop_o(eop_o), .val_o(val_o), .err_o(err_o)
   );

   sort_feeder #(.AWIDTH(3), .DWIDTH(8), .MIN_LEN(1)) dut1 (
      .clk_i(clk_i), .srst_i(srst_i), .data_i(data_i), .sop_i(sop_i), .eop_i(eop_i),
      .val_i(val1_i), .ready_o(ready1_o), .busy_i(busy1_i), .data_o(data1_o),
      .sop_o(sop1_o), .eop_o(eop1_o), .val_o(val1_o), .err_o(err1_o)
   );

   int         checks = 0;
   int         errors = 0;
   int         exp_err, rec_err;
   bit         rand_busy;
   logic [9:0] exp_q[$];
   logic [9:0] got_q[$];
   logic [7:0] m_cur[$];
   bit         m_in_pkt, m_drop;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk_i);
      #1;
      if (val_o) got_q.push_back({sop_o, eop_o, data_o});
      if (err_o) rec_err++;
      if (rand_busy) busy_i = ($urandom_range(0, 3) != 0);
   endtask

   // Reference: what the sorter should receive for one accepted source word.
   task automatic model_word(input logic [7:0] d, input bit s, input bit e);
      bit bad;
      bad = 1'b0;
      if (s && !(m_drop && e)) begin
         bad = m_in_pkt;
         m_cur.delete();
         m_cur.push_back(d);
         m_in_pkt = 1'b1;
         m_drop   = 1'b0;
      end else if (m_drop) begin
         if (e) m_drop = 1'b0;
      end else if (!m_in_pkt) begin
         bad = 1'b1;
      end else if (m_cur.size() == MAX_LEN) begin
         bad      = 1'b1;
         m_in_pkt = 1'b0;
         m_drop   = !e;
      end else begin
         m_cur.push_back(d);
      end
      if (m_in_pkt && e) begin
         if (m_cur.size() < MIN_LEN) bad = 1'b1;
         else foreach (m_cur[i]) exp_q.push_back({i == 0, i == m_cur.size() - 1, m_cur[i]});
         m_in_pkt = 1'b0;
      end
      if (bad) exp_err++;
   endtask

   task automatic drive_word(input logic [7:0] d, input bit s, input bit e);
      bit acc;
      acc    = 1'b0;
      data_i = d;
      sop_i  = s;
      eop_i  = e;
      val_i  = 1'b1;
      for (int n = 0; n < 300 && !acc; n++) begin
         acc = ready_o;
         cycle();
      end
      val_i = 1'b0;
      sop_i = 1'b0;
      eop_i = 1'b0;
      check("accept", acc, 1);
      if (acc) model_word(d, s, e);
   endtask

   task automatic drain();
      bit idle;
      idle   = 1'b0;
      busy_i = 1'b0;
      for (int n = 0; n < 200 && !idle; n++) begin
         cycle();
         idle = ready_o && !val_o;
      end
      check("drain_idle", idle, 1);
   endtask

   task automatic compare(input string tag);
      int n;
      check({tag, "_count"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check({tag, "_word"}, got_q[i], exp_q[i]);
      check({tag, "_errs"}, rec_err, exp_err);
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int len, kind;
      bit s, e;
      srst_i = 1'b1; data_i = '0; sop_i = 0; eop_i = 0; val_i = 0; busy_i = 0;
      val1_i = 0; busy1_i = 0; rand_busy = 0;
      m_in_pkt = 0; m_drop = 0; exp_err = 0; rec_err = 0;
      cycle();
      cycle();
      check("rst_outs", {ready_o, val_o, sop_o, eop_o, err_o, data_o}, {1'b1, 4'b0000, 8'h00});
      check("rst_outs1", {ready1_o, val1_o, sop1_o, eop1_o, err1_o}, 5'b10000);
      srst_i = 1'b0;
      cycle();

      // 1: basic packet, sorter idle
      drive_word(8'd5, 1, 0);
      drive_word(8'd3, 0, 0);
      drive_word(8'd7, 0, 1);
      check("t1_ready_low", ready_o, 0);
      cycle(); check("t1_gap", val_o, 0);
      cycle(); check("t1_w0", {val_o, sop_o, eop_o, data_o}, {3'b110, 8'd5});
      cycle(); check("t1_w1", {val_o, sop_o, eop_o, data_o}, {3'b100, 8'd3});
      cycle(); check("t1_w2", {val_o, sop_o, eop_o, data_o}, {3'b101, 8'd7});
      cycle(); check("t1_ready_back", {ready_o, val_o}, 2'b10);
      compare("t1");

      // 2: sorter busy holds the packet
      busy_i = 1'b1;
      drive_word(8'd5, 1, 0);
      drive_word(8'd3, 0, 0);
      drive_word(8'd7, 0, 1);
      for (int k = 0; k < 10; k++) begin
         cycle();
         check("t2_hold", {ready_o, val_o}, 2'b00);
      end
      busy_i = 1'b0;
      cycle(); check("t2_gap", val_o, 0);
      cycle(); check("t2_sop", {val_o, sop_o, data_o}, {2'b11, 8'd5});
      drain();
      compare("t2");

      // 3: overflow then a maximum-length packet
      for (int i = 0; i < 11; i++) begin
         drive_word(8'(8'h40 + i), i == 0, i == 10);
         if (i == 8) check("t3_ovf_err", err_o, 1);
         if (i == 9) check("t3_err_once", err_o, 0);
      end
      drain();
      compare("t3_drop");
      for (int i = 0; i < 8; i++) drive_word(8'(8'h80 + i), i == 0, i == 7);
      drain();
      compare("t3_max");

      // 4: stray word, then sop mid-packet
      drive_word(8'h55, 0, 0);
      check("t4_stray_err", err_o, 1);
      cycle(); check("t4_stray_pulse", err_o, 0);
      drive_word(8'hAA, 1, 0);
      drive_word(8'hBB, 0, 0);
      drive_word(8'd1, 1, 0);
      check("t4_restart_err", err_o, 1);
      drive_word(8'd2, 0, 1);
      drain();
      compare("t4");

      // 5: single-word packet, too short here, legal on the MIN_LEN=1 instance
      drive_word(8'h3C, 1, 1);
      check("t5_short_err", err_o, 1);
      drain();
      compare("t5a");
      data_i = 8'h3C; sop_i = 1; eop_i = 1; val1_i = 1;
      cycle();
      val1_i = 0; sop_i = 0; eop_i = 0;
      check("t5_ready1_low", ready1_o, 0);
      cycle(); check("t5_gap1", val1_o, 0);
      cycle(); check("t5_single", {val1_o, sop1_o, eop1_o, err1_o, data1_o}, {4'b1110, 8'h3C});
      cycle(); check("t5_ready1_back", {ready1_o, val1_o}, 2'b10);

      // 6: asynchronous reset during SEND
      drive_word(8'h11, 1, 0);
      drive_word(8'h12, 0, 0);
      drive_word(8'h13, 0, 0);
      drive_word(8'h14, 0, 1);
      cycle();
      cycle(); check("t6_sending", {val_o, sop_o, data_o}, {2'b11, 8'h11});
      #2 srst_i = 1'b1;
      #1 check("t6_async_rst", {ready_o, val_o, sop_o, eop_o, err_o, data_o}, {1'b1, 4'b0000, 8'h00});
      #1 srst_i = 1'b0;
      m_in_pkt = 0; m_drop = 0; m_cur.delete();
      got_q.delete(); exp_q.delete();
      exp_err = 0; rec_err = 0;
      cycle();
      drive_word(8'h21, 1, 0);
      drive_word(8'h22, 0, 0);
      drive_word(8'h23, 0, 1);
      drain();
      compare("t6");

      // randomized framing, gaps and busy
      rand_busy = 1'b1;
      for (int p = 0; p < 40; p++) begin
         len  = $urandom_range(1, 11);
         kind = $urandom_range(0, 9);
         for (int i = 0; i < len; i++) begin
            s = (i == 0);
            e = (i == len - 1);
            if (kind == 0 && i == 0) s = 1'b0;
            if (kind == 1 && i == len / 2) s = 1'b1;
            if (kind == 2 && i == len - 1) e = 1'b0;
            repeat ($urandom_range(0, 2)) cycle();
            drive_word(8'($urandom), s, e);
         end
      end
      rand_busy = 1'b0;
      drain();
      compare("rand");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
